// File: rtl/mac_pkg.sv
// Shared widths and arithmetic helpers for the MAC align/accumulate datapath.
package mac_pkg;
  localparam int EXP_W   = 6;
  localparam int SIG_W   = 22;
  localparam int GUARD   = 3;
  localparam int LANE_W  = SIG_W + GUARD + 1;
  localparam int SUM_W   = 30;
  localparam int ACC_W   = 36;
  localparam int N_LANES = 9;

  typedef logic signed [ACC_W-1:0] acc_t;

  typedef struct packed {
    logic ovf;
    acc_t val;
  } sat_t;

  // Signed add clamped to the accumulator range; ovf flags a clamp.
  function automatic sat_t sat_add(input acc_t a, input acc_t b);
    logic [ACC_W:0] wide;
    sat_t r;
    wide = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    r.ovf = wide[ACC_W] ^ wide[ACC_W-1];
    if (r.ovf)
      r.val = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      r.val = wide[ACC_W-1:0];
    return r;
  endfunction

  function automatic acc_t asr_fill(input acc_t x, input logic [EXP_W-1:0] sh);
    if (sh >= EXP_W'(ACC_W))
      return {ACC_W{x[ACC_W-1]}};
    return x >>> sh;
  endfunction
endpackage

// File: rtl/lane_align.sv
// One S1 lane: aligns a product significand to the group maximum exponent
// and applies skip zeroing and the lane sign.
module lane_align
  import mac_pkg::*;
(
  input  logic [EXP_W-1:0]         max_exp,
  input  logic [EXP_W-1:0]         lane_exp,
  input  logic [SIG_W-1:0]         sig,
  input  logic                     sign,
  input  logic                     skip,
  output logic signed [LANE_W-1:0] val
);
  localparam logic [EXP_W-1:0] D_LIMIT = EXP_W'(SIG_W + GUARD);

  logic [EXP_W-1:0]       d;
  logic [SIG_W+GUARD-1:0] mag;
  logic                   zero;

  always_comb begin
    d = max_exp - lane_exp;
    // An exponent above the group maximum is malformed input and is dropped like a skip
    zero = skip || (lane_exp > max_exp) || (d >= D_LIMIT);
    mag = zero ? '0 : ({sig, {GUARD{1'b0}}} >> d);
    val = sign ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  end
endmodule

// File: rtl/align_accum.sv
// Aligns nine product lanes to the group exponent, sums them and accumulates
// partial sums across the passes of a group; one result per group out.
module align_accum
  import mac_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic                       i_last,
  input  logic [N_LANES-1:0]         i_skip,
  input  logic [EXP_W-1:0]           i_max_exp,
  input  logic [N_LANES-1:0]         i_sign,
  input  logic [N_LANES*EXP_W-1:0]   i_exp,
  input  logic [N_LANES*SIG_W-1:0]   i_sig,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic signed [ACC_W-1:0]    o_sum,
  output logic [EXP_W-1:0]           o_exp,
  output logic                       o_ovf
);
  logic                       in_v, in_last;
  logic [N_LANES-1:0]         in_skip, in_sign;
  logic [EXP_W-1:0]           in_max;
  logic [N_LANES*EXP_W-1:0]   in_exp;
  logic [N_LANES*SIG_W-1:0]   in_sig;

  logic                       s1_v, s1_last;
  logic [EXP_W-1:0]           s1_exp;
  logic signed [LANE_W-1:0]   s1_lane [N_LANES];
  logic signed [LANE_W-1:0]   lane_val [N_LANES];

  logic                       s2_v, s2_last;
  logic [EXP_W-1:0]           s2_exp;
  logic signed [SUM_W-1:0]    s2_sum, lane_sum;

  acc_t                       acc, part_ext, acc_al, part_al, comb_val;
  logic [EXP_W-1:0]           acc_exp, exp_diff, comb_exp;
  logic                       acc_empty, ovf_g, acc_behind, comb_ovf;
  sat_t                       sum_sat;

  assign o_ready = !(o_valid && !i_ready);

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    lane_align u_lane (
      .max_exp  (in_max),
      .lane_exp (in_exp[k*EXP_W +: EXP_W]),
      .sig      (in_sig[k*SIG_W +: SIG_W]),
      .sign     (in_sign[k]),
      .skip     (in_skip[N_LANES-1-k]),
      .val      (lane_val[k])
    );
  end

  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < N_LANES; k++)
      lane_sum = lane_sum + {{(SUM_W-LANE_W){s1_lane[k][LANE_W-1]}}, s1_lane[k]};
  end

  // The side with the smaller exponent is shifted down before the saturating add
  always_comb begin
    part_ext   = {{(ACC_W-SUM_W){s2_sum[SUM_W-1]}}, s2_sum};
    acc_behind = acc_exp < s2_exp;
    exp_diff   = acc_behind ? (s2_exp - acc_exp) : (acc_exp - s2_exp);
    acc_al     = acc_behind ? asr_fill(acc, exp_diff) : acc;
    part_al    = acc_behind ? part_ext : asr_fill(part_ext, exp_diff);
    sum_sat    = sat_add(acc_al, part_al);
    if (acc_empty) begin
      comb_val = part_ext;
      comb_exp = s2_exp;
      comb_ovf = 1'b0;
    end else begin
      comb_val = sum_sat.val;
      comb_exp = acc_behind ? s2_exp : acc_exp;
      comb_ovf = sum_sat.ovf;
    end
  end

  // Every stage advances only while the output side can move, so a stall freezes all of them
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      in_v <= 1'b0; in_last <= 1'b0; in_skip <= '0; in_sign <= '0;
      in_max <= '0; in_exp <= '0; in_sig <= '0;
      s1_v <= 1'b0; s1_last <= 1'b0; s1_exp <= '0;
      for (int k = 0; k < N_LANES; k++) s1_lane[k] <= '0;
      s2_v <= 1'b0; s2_last <= 1'b0; s2_exp <= '0; s2_sum <= '0;
      acc <= '0; acc_exp <= '0; acc_empty <= 1'b1; ovf_g <= 1'b0;
      o_valid <= 1'b0; o_sum <= '0; o_exp <= '0; o_ovf <= 1'b0;
    end else if (o_ready) begin
      in_v <= i_valid; in_last <= i_last; in_skip <= i_skip; in_sign <= i_sign;
      in_max <= i_max_exp; in_exp <= i_exp; in_sig <= i_sig;
      s1_v <= in_v; s1_last <= in_last; s1_exp <= in_max; s1_lane <= lane_val;
      s2_v <= s1_v; s2_last <= s1_last; s2_exp <= s1_exp; s2_sum <= lane_sum;
      o_valid <= s2_v && s2_last;
      if (s2_v) begin
        if (s2_last) begin
          o_sum <= comb_val; o_exp <= comb_exp; o_ovf <= ovf_g | comb_ovf;
          acc <= '0; acc_exp <= '0; acc_empty <= 1'b1; ovf_g <= 1'b0;
        end else begin
          acc <= comb_val; acc_exp <= comb_exp; acc_empty <= 1'b0;
          ovf_g <= ovf_g | comb_ovf;
        end
      end
    end
  end
endmodule

// File: tb/tb_align_accum.sv
// Directed bench for align_accum: expected group results are queued at issue
// time and a monitor pops and compares them as the DUT hands results out.
`timescale 1ns/1ps
module tb_align_accum;
  import mac_pkg::*;

  logic               i_clk = 1'b0;
  logic               i_rst, i_valid, i_last, i_ready;
  logic               o_ready, o_valid, o_ovf;
  logic [8:0]         i_skip, i_sign;
  logic [5:0]         i_max_exp, o_exp;
  logic [53:0]        i_exp;
  logic [197:0]       i_sig;
  logic signed [35:0] o_sum;

  typedef struct packed {
    logic [35:0] sum;
    logic [5:0]  exp;
    logic        ovf;
  } result_t;

  result_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int result_idx = 0;

  always #5 i_clk = ~i_clk;

  align_accum dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_last(i_last), .i_skip(i_skip), .i_max_exp(i_max_exp), .i_sign(i_sign),
    .i_exp(i_exp), .i_sig(i_sig), .o_valid(o_valid), .i_ready(i_ready),
    .o_sum(o_sum), .o_exp(o_exp), .o_ovf(o_ovf)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: inputs change just after the rising edge, so the falling edge sees the handshake that will happen
  always @(negedge i_clk) begin
    result_t e;
    if (!i_rst && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_result: got sum 0x%0h exp %0d, expected no result", o_sum, o_exp);
      end else begin
        e = exp_q.pop_front();
        checkOutput($sformatf("result%0d_sum", result_idx), 64'($unsigned(o_sum)), 64'(e.sum));
        checkOutput($sformatf("result%0d_exp", result_idx), 64'(o_exp), 64'(e.exp));
        checkOutput($sformatf("result%0d_ovf", result_idx), 64'(o_ovf), 64'(e.ovf));
        result_idx++;
      end
    end
  end

  task automatic clearPass(input logic [5:0] max_e);
    i_max_exp = max_e;
    i_skip = 9'h1FF;
    i_sign = '0;
    for (int k = 0; k < 9; k++) begin
      i_exp[k*6 +: 6] = max_e;
      i_sig[k*22 +: 22] = 22'h3FFFFF;
    end
  endtask

  task automatic setLane(input int k, input logic s, input logic [5:0] e, input logic [21:0] g);
    i_skip[8-k] = 1'b0;
    i_sign[k] = s;
    i_exp[k*6 +: 6] = e;
    i_sig[k*22 +: 22] = g;
  endtask

  task automatic applyStimulus(input logic last, input logic [35:0] esum, input logic [5:0] eexp, input logic eovf);
    bit accepted;
    result_t r;
    accepted = 1'b0;
    i_last = last;
    i_valid = 1'b1;
    for (int n = 0; n < 100 && !accepted; n++) begin
      accepted = o_ready;
      if (accepted && last) begin
        r.sum = esum;
        r.exp = eexp;
        r.ovf = eovf;
        exp_q.push_back(r);
      end
      @(posedge i_clk); #1;
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: o_ready=%0b, expected 1 within 100 cycles", o_ready);
    end
  endtask

  task automatic idle();
    i_valid = 1'b0;
    i_last = 1'b0;
  endtask

  task automatic waitDrain();
    for (int n = 0; n < 300 && exp_q.size() != 0; n++) begin
      @(posedge i_clk); #1;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
    end
    repeat (2) @(posedge i_clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_rst = 1'b1;
    i_ready = 1'b1;
    idle();
    clearPass(6'd0);
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("reset_o_valid", 64'(o_valid), 64'd0);
    checkOutput("reset_o_ready", 64'(o_ready), 64'd1);
    checkOutput("reset_o_sum", 64'($unsigned(o_sum)), 64'd0);
    checkOutput("reset_o_exp", 64'(o_exp), 64'd0);
    checkOutput("reset_o_ovf", 64'(o_ovf), 64'd0);
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    // All nine lanes at the group exponent, with a three-cycle latency check
    clearPass(6'd30);
    for (int k = 0; k < 9; k++) setLane(k, 1'b0, 6'd30, 22'h200000);
    applyStimulus(1'b1, 36'h009000000, 6'd30, 1'b0);
    idle();
    for (int n = 0; n < 3; n++) begin
      checkOutput($sformatf("latency_idle%0d", n), 64'(o_valid), 64'd0);
      @(posedge i_clk); #1;
    end
    checkOutput("latency_valid", 64'(o_valid), 64'd1);
    waitDrain();

    clearPass(6'd30);
    setLane(1, 1'b0, 6'd28, 22'h200000);
    applyStimulus(1'b1, 36'h000400000, 6'd30, 1'b0);
    clearPass(6'd30);
    setLane(1, 1'b0, 6'd5, 22'h200000);
    applyStimulus(1'b1, 36'h0, 6'd30, 1'b0);
    clearPass(6'd30);
    setLane(3, 1'b0, 6'd6, 22'h3FFFFF);
    applyStimulus(1'b1, 36'h1, 6'd30, 1'b0);
    clearPass(6'd10);
    setLane(2, 1'b0, 6'd10, 22'h200000);
    setLane(6, 1'b0, 6'd60, 22'h3FFFFF);
    applyStimulus(1'b1, 36'h001000000, 6'd10, 1'b0);
    clearPass(6'd20);
    setLane(0, 1'b1, 6'd20, 22'h200000);
    setLane(2, 1'b0, 6'd20, 22'h100000);
    applyStimulus(1'b1, 36'hFFF800000, 6'd20, 1'b0);

    // Multi-pass groups streamed back to back: exponent growing, shrinking, and a shift past the width
    clearPass(6'd30);
    setLane(5, 1'b0, 6'd30, 22'h200000);
    applyStimulus(1'b0, 36'h0, 6'd0, 1'b0);
    clearPass(6'd32);
    setLane(7, 1'b0, 6'd32, 22'h200000);
    applyStimulus(1'b1, 36'h001400000, 6'd32, 1'b0);
    clearPass(6'd32);
    setLane(5, 1'b0, 6'd32, 22'h200000);
    applyStimulus(1'b0, 36'h0, 6'd0, 1'b0);
    clearPass(6'd30);
    setLane(7, 1'b0, 6'd30, 22'h300000);
    applyStimulus(1'b1, 36'h001600000, 6'd32, 1'b0);
    clearPass(6'd0);
    setLane(8, 1'b1, 6'd0, 22'h200000);
    applyStimulus(1'b0, 36'h0, 6'd0, 1'b0);
    clearPass(6'd63);
    setLane(8, 1'b0, 6'd63, 22'h200000);
    applyStimulus(1'b1, 36'h000FFFFFF, 6'd63, 1'b0);
    idle();
    waitDrain();

    // Backpressure: one result held with three passes queued behind it
    i_ready = 1'b0;
    clearPass(6'd10);
    setLane(0, 1'b0, 6'd10, 22'h000001);
    applyStimulus(1'b1, 36'h8, 6'd10, 1'b0);
    clearPass(6'd11);
    setLane(0, 1'b0, 6'd11, 22'h000002);
    applyStimulus(1'b1, 36'h10, 6'd11, 1'b0);
    clearPass(6'd12);
    setLane(0, 1'b1, 6'd12, 22'h000003);
    applyStimulus(1'b1, 36'hFFFFFFFE8, 6'd12, 1'b0);
    clearPass(6'd13);
    setLane(0, 1'b0, 6'd12, 22'h3FFFFF);
    applyStimulus(1'b1, 36'h000FFFFFC, 6'd13, 1'b0);
    idle();
    for (int n = 0; n < 5; n++) begin
      checkOutput($sformatf("stall%0d_o_ready", n), 64'(o_ready), 64'd0);
      checkOutput($sformatf("stall%0d_o_valid", n), 64'(o_valid), 64'd1);
      checkOutput($sformatf("stall%0d_o_sum", n), 64'($unsigned(o_sum)), 64'h8);
      @(posedge i_clk); #1;
    end
    i_ready = 1'b1;
    waitDrain();

    // Reset between the first pass and the closing pass drops the partial group
    clearPass(6'd30);
    setLane(0, 1'b0, 6'd30, 22'h200000);
    applyStimulus(1'b0, 36'h0, 6'd0, 1'b0);
    idle();
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("midreset_o_valid", 64'(o_valid), 64'd0);
    checkOutput("midreset_o_ready", 64'(o_ready), 64'd1);
    checkOutput("midreset_o_sum", 64'($unsigned(o_sum)), 64'd0);
    checkOutput("midreset_o_exp", 64'(o_exp), 64'd0);
    i_rst = 1'b0;
    repeat (5) @(posedge i_clk);
    #1;
    checkOutput("postreset_o_valid", 64'(o_valid), 64'd0);
    clearPass(6'd32);
    setLane(0, 1'b0, 6'd32, 22'h200000);
    applyStimulus(1'b1, 36'h001000000, 6'd32, 1'b0);
    idle();
    waitDrain();

    // Saturation: 120 full-scale passes exceed the positive limit after pass 114
    clearPass(6'd20);
    i_skip = '0;
    for (int i = 0; i < 120; i++)
      applyStimulus(i == 119, 36'h7FFFFFFFF, 6'd20, 1'b1);
    clearPass(6'd20);
    setLane(0, 1'b0, 6'd20, 22'h200000);
    applyStimulus(1'b1, 36'h001000000, 6'd20, 1'b0);
    idle();
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
